// File: rtl/digit_count_arbiter.sv
// rtl/digit_count_arbiter.sv - round-robin front end for a shared iterative decimal digit counter
// One divide-by-10 per CALC cycle on the granted operand; the result is returned tagged with the requester id.
module digit_count_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_number,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_digits,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [IDW-1:0]     last_q, last_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IDW-1:0]     resp_id_q, resp_id_d;
    logic [WIDTH-1:0]   resp_digits_q, resp_digits_d;

    logic [WIDTH-1:0]   operand [NREQ];
    logic [IDW-1:0]     winner;
    logic               any_valid;
    logic [IDW-1:0]     scan_idx;
    int                 scan_sum;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            operand[i] = req_number[i*WIDTH +: WIDTH];
        end
    end

    // Scan from last+1 upward with wrap; the first valid requester wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        scan_sum  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_sum = int'(last_q) + k;
            if (scan_sum >= NREQ) begin
                scan_sum = scan_sum - NREQ;
            end
            scan_idx = IDW'(scan_sum);
            if (!any_valid && req_valid[scan_idx]) begin
                any_valid = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    assign req_ready = (state_q == IDLE && !rst && any_valid) ? (NREQ'(1) << winner) : '0;

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        count_d       = count_q;
        gid_d         = gid_q;
        last_d        = last_q;
        resp_valid_d  = 1'b0;
        resp_id_d     = resp_id_q;
        resp_digits_d = resp_digits_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    work_d  = operand[winner];
                    count_d = '0;
                    gid_d   = winner;
                    last_d  = winner;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (work_q != '0) begin
                    work_d  = work_q / WIDTH'(10);
                    count_d = count_q + WIDTH'(1);
                end else begin
                    resp_digits_d = count_q;
                    resp_id_d     = gid_q;
                    resp_valid_d  = 1'b1;
                    state_d       = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            work_q        <= '0;
            count_q       <= '0;
            gid_q         <= '0;
            last_q        <= IDW'(NREQ - 1);
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_digits_q <= '0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            count_q       <= count_d;
            gid_q         <= gid_d;
            last_q        <= last_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_digits_q <= resp_digits_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_digits = resp_digits_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_digit_count_arbiter.sv
// tb/tb_digit_count_arbiter.sv - scoreboard bench for digit_count_arbiter
// Expected results are queued at each handshake and compared when resp_valid pulses.
module tb_digit_count_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_number;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_digits;
    logic                  busy;

    digit_count_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_number  (req_number),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_digits (resp_digits),
        .busy        (busy)
    );

    typedef struct {
        int id;
        int digits;
        int due;
    } exp_t;

    exp_t sb [$];
    int   grant_log [$];
    int   grant_cyc [$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   base;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Digit count as the number of powers of ten (1..1e9) not exceeding n.
    function automatic int ref_digits(input logic [31:0] n);
        int     d = 0;
        longint p = 1;
        for (int k = 0; k < 10; k++) begin
            if (longint'(n) >= p) d++;
            p = p * 10;
        end
        return d;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("ready_in_rst", req_ready, 0);
            sb.delete();
        end else begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", resp_id, e.id);
                    check("resp_digits", resp_digits, e.digits);
                    check("resp_cycle", cyc, e.due);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id     = i;
                    e.digits = ref_digits(req_number[i*WIDTH +: WIDTH]);
                    e.due    = cyc + e.digits + 2;
                    sb.push_back(e);
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_num(input int i, input logic [31:0] v);
        req_number[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        tick();
    endtask

    task automatic wait_grants(input int target);
        int n = 0;
        while (grant_log.size() < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("grant_timeout", grant_log.size() >= target, 1);
    endtask

    task automatic single_req(input int id, input logic [31:0] v);
        tick();
        set_num(id, v);
        req_valid = NREQ'(1) << id;
        tick();
        req_valid = '0;
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_number = '0;
        for (int i = 0; i < NREQ; i++) set_num(i, 32'(100 + i));
        repeat (4) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_id", resp_id, 0);
        check("reset_resp_digits", resp_digits, 0);
        check("reset_busy", busy, 0);

        // Lone requester 2 with 12345: grant, then busy exactly over CALC+DONE.
        tick();
        set_num(2, 32'd12345);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_busy", busy, (k <= 7) ? 1 : 0);
        end
        drain();

        single_req(1, 32'd0);
        single_req(3, 32'hFFFF_FFFF);

        // All four held: strict rotation and back-to-back spacing of d+3.
        base = grant_log.size();
        tick();
        set_num(0, 32'd7);
        set_num(1, 32'd70);
        set_num(2, 32'd700);
        set_num(3, 32'd7000);
        req_valid = 4'b1111;
        wait_grants(base + 5);
        tick();
        req_valid = '0;
        if (grant_log.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) check("rr4_order", grant_log[base+k], k % 4);
            for (int k = 0; k < 4; k++)
                check("rr4_spacing", grant_cyc[base+k+1] - grant_cyc[base+k], ref_digits(32'(7 * (10 ** k))) + 3);
        end
        drain();

        // Grant to 1, then 1 and 3 contend with operands changing while waiting.
        base = grant_log.size();
        tick();
        set_num(1, 32'd5);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        set_num(1, 32'd111);
        set_num(3, 32'd22);
        tick();
        tick();
        set_num(3, 32'd123456);
        set_num(1, 32'd9);
        wait_grants(base + 2);
        tick();
        set_num(1, 32'd1000000);
        wait_grants(base + 3);
        tick();
        req_valid = '0;
        if (grant_log.size() >= base + 3) begin
            check("rr2_first", grant_log[base], 1);
            check("rr2_second", grant_log[base+1], 3);
            check("rr2_third", grant_log[base+2], 1);
        end
        drain();

        // Reset in the third CALC cycle abandons the operation.
        tick();
        set_num(2, 32'd99999);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_resp_id", resp_id, 0);
        check("abort_resp_digits", resp_digits, 0);
        check("abort_busy", busy, 0);
        repeat (12) @(negedge clk);
        base = grant_log.size();
        tick();
        set_num(0, 32'd5);
        set_num(3, 32'd55);
        req_valid = 4'b1001;
        wait_grants(base + 2);
        tick();
        req_valid = '0;
        if (grant_log.size() >= base + 2) begin
            check("post_rst_first", grant_log[base], 0);
            check("post_rst_second", grant_log[base+1], 3);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/digit_count_arbiter.md
# digit_count_arbiter

Shared front end for the iterative decimal digit-count engine. It arbitrates up to NREQ requesters round-robin and runs one divide-by-10 per cycle on the granted number. It returns the digit count tagged with the requester id. It sits between the client blocks and the single digit-count datapath, so the divider is instantiated once instead of per client.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand and count width
- IDW, $clog2(NREQ), width of the id field
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  NREQ  bit i: requester i has an operand
- req_number  input  NREQ*WIDTH  operand i in bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot grant/accept; handshake when req_valid[i] and req_ready[i]
- resp_valid  output  1  one-cycle pulse, result available
- resp_id  output  IDW  requester the result belongs to
- resp_digits  output  WIDTH  decimal digit count of the accepted operand
- busy  output  1  high whenever the state is not IDLE

## Operation
- Clocking and reset are fixed: one clock, `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, CALC, DONE. Reset puts the block in IDLE.
- Reset values:
  - resp_valid=0, resp_id=0, resp_digits=0, busy=0.
  - Internal work=0, count=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
- IDLE:
  - req_ready is combinational. The winner is the first i with req_valid[i] set, scanning from last+1 upward modulo NREQ.
  - req_ready[winner]=1; every other bit is 0. If no req_valid bit is set, req_ready=0.
  - On handshake: work<=req_number[winner], count<=0, gid<=winner, last<=winner, go to CALC.
- CALC:
  - If work!=0: work<=work/10 (unsigned, truncating) and count<=count+1; stay in CALC.
  - If work==0: resp_digits<=count, resp_id<=gid, resp_valid<=1; go to DONE.
- DONE: resp_valid is high for exactly this cycle. Go to IDLE; resp_valid<=0.
- req_ready is 0 in CALC and DONE, and in any cycle where rst=1.
- Arithmetic is unsigned.
  - Operand 0 yields a count of 0 (zero is counted as no digits).
  - count never exceeds ceil(WIDTH*log10(2)), which is 10 for WIDTH=32, so it does not wrap.
- resp_id and resp_digits hold their last value until the next DONE.
- No response backpressure: clients must sample the result during the resp_valid cycle.
- Requesters may drop or change req_valid and req_number freely while not granted. Only the operand present at the handshake cycle is used.
- Reset in CALC or DONE:
  - The operation is abandoned; no resp_valid pulse follows.
  - The pointer returns to NREQ-1 and all outputs return to their reset values on the next edge.

## Timing
- Handshake in cycle T. CALC occupies T+1 through T+d+1, where d is the digit count. resp_valid is high in cycle T+d+2.
- Operand 0: resp_valid in cycle T+2. Operand 4294967295: resp_valid in T+12.
- The earliest next handshake is T+d+3 (IDLE after DONE). Back-to-back throughput is one operation per d+3 cycles.
- Grant decision is combinational from req_valid and last. All other outputs are registered.
- busy=1 from T+1 through T+d+2 inclusive.
- Simultaneous requests are resolved strictly by the round-robin order above. A requester that holds req_valid is granted within NREQ operations.

## Test plan
- Reset, then only req_valid[2] with number=12345 at T:
  - req_ready=4'b0100 at T.
  - resp_valid at T+7 with resp_id=2, resp_digits=5.
  - busy high T+1..T+7.
- Single request with number=0: resp_valid at T+2, resp_digits=0. Number=4294967295: resp_valid at T+12, resp_digits=10.
- All four req_valid held high with numbers 7, 70, 700, 7000:
  - Grants occur in order 0,1,2,3,0.
  - Results are (id0,1), (id1,2), (id2,3), (id3,4).
  - Each new grant comes exactly one cycle after the previous resp_valid cycle.
- req_valid[1] and req_valid[3] high after a grant to 1: next grant goes to 3, then 1. Operands are changed while waiting, and the result must match the value present at handshake.
- Assert rst in the third CALC cycle of number=99999:
  - No resp_valid occurs; outputs read 0 after the reset edge.
  - The next request from 3 and 0 together grants 0 first.
- rst held high with req_valid=4'b1111: req_ready stays 0 and no state change occurs until rst drops.
